reg_wb_arbiter: RTL and testbench

- Owns the single write port of the LC3 8x16 register file: rf_en, rf_dr, rf_data.
- After reset, sequences an initialisation pass that writes INIT_VALUE to R0..R7, since the register file itself resets to unknown.
- In normal operation, arbitrates writebacks between the ALU/execute path and the memory/load path using valid/ready handshakes.
- Keeps an 8-bit busy scoreboard so decode can stall on pending destination registers.

---
 rtl/reg_wb_arbiter.sv | 110 +++++++++++
 tb/tb_reg_wb_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_wb_arbiter.sv
// rtl/reg_wb_arbiter.sv - LC3 register-file write-port arbiter with init sequencer and busy scoreboard
module reg_wb_arbiter #(
    parameter int          STARVE_LIMIT = 3,
    parameter logic [15:0] INIT_VALUE   = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [2:0]  alu_dr,
    input  logic [15:0] alu_data,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [2:0]  mem_dr,
    input  logic [15:0] mem_data,
    input  logic        rsv_en,
    input  logic [2:0]  rsv_dr,
    output logic [7:0]  busy,
    output logic        init_done,
    output logic        rf_en,
    output logic [2:0]  rf_dr,
    output logic [15:0] rf_data
);

    typedef enum logic {S_INIT, S_RUN} state_t;

    localparam logic [3:0] STARVE_LIM4 = 4'(STARVE_LIMIT);

    state_t      state, state_nx;
    logic [2:0]  idx;
    logic [3:0]  starve_cnt;
    logic        wb_fire;
    logic [2:0]  wb_dr;
    logic [15:0] wb_data;
    logic [7:0]  busy_nx;

    always_comb begin
        state_nx  = state;
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        if (state == S_INIT && idx == 3'd7) begin
            state_nx = S_RUN;
        end
        // Loads win conflicts until the ALU has waited STARVE_LIMIT cycles
        if (state == S_RUN && !rst) begin
            if (mem_valid && (!alu_valid || starve_cnt < STARVE_LIM4)) begin
                mem_ready = 1'b1;
            end else if (alu_valid) begin
                alu_ready = 1'b1;
            end
        end
    end

    always_comb begin
        wb_fire = alu_ready | mem_ready;
        wb_dr   = mem_ready ? mem_dr   : alu_dr;
        wb_data = mem_ready ? mem_data : alu_data;
        busy_nx = busy;
        if (state == S_RUN) begin
            if (wb_fire) begin
                busy_nx[wb_dr] = 1'b0;
            end
            // A same-cycle reservation is younger than the completing write
            if (rsv_en) begin
                busy_nx[rsv_dr] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_INIT;
            idx        <= 3'd0;
            rf_en      <= 1'b0;
            rf_dr      <= 3'd0;
            rf_data    <= 16'h0000;
            busy       <= 8'h00;
            init_done  <= 1'b0;
            starve_cnt <= 4'd0;
        end else begin
            state <= state_nx;
            busy  <= busy_nx;
            if (state == S_INIT) begin
                rf_en   <= 1'b1;
                rf_dr   <= idx;
                rf_data <= INIT_VALUE;
                if (idx == 3'd7) begin
                    init_done <= 1'b1;
                    idx       <= 3'd0;
                end else begin
                    idx <= idx + 3'd1;
                end
            end else begin
                rf_en <= wb_fire;
                if (wb_fire) begin
                    rf_dr   <= wb_dr;
                    rf_data <= wb_data;
                end
            end
            if (alu_valid && mem_ready) begin
                if (starve_cnt != 4'd15) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end else if (alu_ready || !alu_valid) begin
                starve_cnt <= 4'd0;
            end
        end
    end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb/tb_reg_wb_arbiter.sv - directed self-checking bench for reg_wb_arbiter
module tb_reg_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0, mem_valid = 1'b0, rsv_en = 1'b0;
    logic        alu_ready, mem_ready;
    logic [2:0]  alu_dr = 3'd0, mem_dr = 3'd0, rsv_dr = 3'd0;
    logic [15:0] alu_data = 16'h0, mem_data = 16'h0;
    logic [7:0]  busy;
    logic        init_done, rf_en;
    logic [2:0]  rf_dr;
    logic [15:0] rf_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    reg_wb_arbiter #(.STARVE_LIMIT(3), .INIT_VALUE(16'h0000)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dr(alu_dr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dr(mem_dr), .mem_data(mem_data),
        .rsv_en(rsv_en), .rsv_dr(rsv_dr), .busy(busy), .init_done(init_done),
        .rf_en(rf_en), .rf_dr(rf_dr), .rf_data(rf_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_init_sequence(input string tag);
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (rf_en !== 1'b1 || rf_dr !== 3'(i) || rf_data !== 16'h0000) begin
                errors++;
                $display("FAIL %s_write%0d: got en=%b dr=%0d data=%h, want en=1 dr=%0d data=0000",
                         tag, i, rf_en, rf_dr, rf_data, i);
            end
            checks++;
            if (init_done !== (i == 7)) begin
                errors++;
                $display("FAIL %s_init_done%0d: got %b want %b", tag, i, init_done, (i == 7));
            end
            if (i < 7) begin
                checks++;
                if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_ready%0d: got alu=%b mem=%b want 0 0", tag, i, alu_ready, mem_ready);
                end
            end
        end
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        tick();
        checks++;
        if (rf_en !== 1'b0 || busy !== 8'h00) begin
            errors++;
            $display("FAIL %s_idle: got en=%b busy=%h want en=0 busy=00", tag, rf_en, busy);
        end
    endtask

    task automatic test_reset();
        alu_valid = 1'b1;
        mem_valid = 1'b1;
        tick();
        tick();
        checks++;
        if (rf_en !== 1'b0 || rf_dr !== 3'd0 || rf_data !== 16'h0 || busy !== 8'h00 || init_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got en=%b dr=%0d data=%h busy=%h done=%b want all 0",
                     rf_en, rf_dr, rf_data, busy, init_done);
        end
        checks++;
        if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got alu=%b mem=%b want 0 0", alu_ready, mem_ready);
        end
        rst = 1'b0;
        run_init_sequence("init");
    endtask

    task automatic test_alu_wb();
        alu_valid = 1'b1; alu_dr = 3'd3; alu_data = 16'hBEEF;
        #1;
        checks++;
        if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL alu_grant: got alu=%b mem=%b want 1 0", alu_ready, mem_ready);
        end
        tick();
        alu_valid = 1'b0;
        checks++;
        if (rf_en !== 1'b1 || rf_dr !== 3'd3 || rf_data !== 16'hBEEF) begin
            errors++;
            $display("FAIL alu_write: got en=%b dr=%0d data=%h want 1 3 beef", rf_en, rf_dr, rf_data);
        end
        tick();
        checks++;
        if (rf_en !== 1'b0 || rf_dr !== 3'd3 || rf_data !== 16'hBEEF) begin
            errors++;
            $display("FAIL alu_hold: got en=%b dr=%0d data=%h want 0 3 beef", rf_en, rf_dr, rf_data);
        end
    endtask

    task automatic test_starvation();
        logic exp_mem;
        mem_valid = 1'b1; mem_dr = 3'd1; mem_data = 16'h1111;
        alu_valid = 1'b1; alu_dr = 3'd2; alu_data = 16'h2222;
        for (int k = 0; k < 4; k++) begin
            exp_mem = (k < 3);
            #1;
            checks++;
            if (mem_ready !== exp_mem || alu_ready !== !exp_mem) begin
                errors++;
                $display("FAIL starve_grant%0d: got mem=%b alu=%b want mem=%b alu=%b",
                         k, mem_ready, alu_ready, exp_mem, !exp_mem);
            end
            tick();
            checks++;
            if (rf_en !== 1'b1 || rf_dr !== (exp_mem ? 3'd1 : 3'd2) ||
                rf_data !== (exp_mem ? 16'h1111 : 16'h2222)) begin
                errors++;
                $display("FAIL starve_write%0d: got en=%b dr=%0d data=%h", k, rf_en, rf_dr, rf_data);
            end
        end
        #1;
        checks++;
        if (mem_ready !== 1'b1 || alu_ready !== 1'b0) begin
            errors++;
            $display("FAIL starve_cleared: got mem=%b alu=%b want mem=1 alu=0", mem_ready, alu_ready);
        end
        mem_valid = 1'b0;
        alu_valid = 1'b0;
        tick();
    endtask

    task automatic test_scoreboard();
        rsv_en = 1'b1; rsv_dr = 3'd5;
        tick();
        rsv_en = 1'b0;
        checks++;
        if (busy !== 8'h20) begin
            errors++;
            $display("FAIL sb_reserve: got %h want 20", busy);
        end
        alu_valid = 1'b1; alu_dr = 3'd5; alu_data = 16'h5555;
        rsv_en = 1'b1; rsv_dr = 3'd5;
        tick();
        alu_valid = 1'b0; rsv_en = 1'b0;
        checks++;
        if (busy !== 8'h20 || rf_en !== 1'b1 || rf_dr !== 3'd5) begin
            errors++;
            $display("FAIL sb_set_wins: got busy=%h en=%b dr=%0d want 20 1 5", busy, rf_en, rf_dr);
        end
        alu_valid = 1'b1;
        rsv_en = 1'b1; rsv_dr = 3'd4;
        tick();
        alu_valid = 1'b0; rsv_en = 1'b0;
        checks++;
        if (busy !== 8'h10) begin
            errors++;
            $display("FAIL sb_independent: got %h want 10", busy);
        end
        alu_valid = 1'b1; alu_dr = 3'd4;
        tick();
        alu_valid = 1'b0;
        checks++;
        if (busy !== 8'h00) begin
            errors++;
            $display("FAIL sb_clear: got %h want 00", busy);
        end
    endtask

    task automatic test_reset_mid_run();
        rsv_en = 1'b1; rsv_dr = 3'd2;
        tick();
        rsv_dr = 3'd6;
        tick();
        rsv_en = 1'b0;
        checks++;
        if (busy !== 8'h44) begin
            errors++;
            $display("FAIL rst_mid_busy: got %h want 44", busy);
        end
        mem_valid = 1'b1; mem_dr = 3'd7; mem_data = 16'hDEAD;
        rst = 1'b1;
        #1;
        checks++;
        if (mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_ready: got %b want 0", mem_ready);
        end
        tick();
        rst = 1'b0;
        mem_valid = 1'b0;
        checks++;
        if (rf_en !== 1'b0 || busy !== 8'h00 || init_done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_state: got en=%b busy=%h done=%b want 0 00 0", rf_en, busy, init_done);
        end
        run_init_sequence("reinit");
    endtask

    task automatic test_nonbusy_wb();
        mem_valid = 1'b1; mem_dr = 3'd0; mem_data = 16'h0042;
        #1;
        checks++;
        if (mem_ready !== 1'b1 || alu_ready !== 1'b0) begin
            errors++;
            $display("FAIL nb_grant: got mem=%b alu=%b want 1 0", mem_ready, alu_ready);
        end
        tick();
        mem_valid = 1'b0;
        checks++;
        if (rf_en !== 1'b1 || rf_dr !== 3'd0 || rf_data !== 16'h0042 || busy !== 8'h00) begin
            errors++;
            $display("FAIL nb_write: got en=%b dr=%0d data=%h busy=%h want 1 0 0042 00",
                     rf_en, rf_dr, rf_data, busy);
        end
        tick();
        checks++;
        if (rf_en !== 1'b0) begin
            errors++;
            $display("FAIL nb_pulse: got en=%b want 0", rf_en);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_alu_wb();
        test_starvation();
        test_scoreboard();
        test_reset_mid_run();
        test_nonbusy_wb();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
